uart_rx: RTL and testbench

// - UART receiver, 8N1, LSB first; the receive counterpart of the design's UART transmitter, same bit timing.
// - Synchronises the asynchronous serial line, detects start bit, samples each bit at mid-bit, presents byte with 1-cycle valid strobe.
// - Sits between the board RX pin and the LFSR command/data logic; no FIFO, so the consumer must take rx_byte on rx_valid.
//

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_datapath.sv | 111 +++++++++++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions.
// Holds the receiver/transmitter state encoding, the default bit period
// (10 MHz system clock, 115200 baud) and small helpers for deriving the
// mid-bit sample point and bit-period counter width from CLKS_PER_BIT.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4,
        ST_BREAK   = 3'd5
    } uart_state_e;

    // Count at which the start bit is re-checked. Together with the one
    // cycle spent detecting the edge this lands on the middle of the bit.
    function automatic int uart_half_bit(input int cpb);
        return (cpb - 1) / 2;
    endfunction

    function automatic int uart_count_width(input int cpb);
        return (cpb <= 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

// File: rtl/uart_rx_datapath.sv
// UART receiver datapath.
// Synchronises the serial line, runs the bit-period counter and the bit
// index, assembles the byte and registers the outputs. It makes no
// decisions itself: the FSM in uart_rx drives the strobes below.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   rx_serial        raw serial line (asynchronous, idle high)
//   cnt_clr          force the bit-period counter to 0
//   idx_clr/idx_inc  clear / advance the bit index
//   shift_en         store rx_s into the bit selected by the bit index
//   byte_load        copy the assembled byte to rx_byte
//   valid_set        rx_valid is high next cycle
//   ferr_set         rx_frame_err is high next cycle
//   rx_s             synchronised serial line
//   full_bit_width   counter is at the last cycle of a bit period
//   half_bit         counter is at the mid-bit check point
//   last_bit         bit index points at bit 7
//   rx_byte, rx_valid, rx_frame_err   registered receiver outputs
module uart_rx_datapath
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    input  logic       cnt_clr,
    input  logic       idx_clr,
    input  logic       idx_inc,
    input  logic       shift_en,
    input  logic       byte_load,
    input  logic       valid_set,
    input  logic       ferr_set,
    output logic       rx_s,
    output logic       full_bit_width,
    output logic       half_bit,
    output logic       last_bit,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int            CW       = uart_count_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(uart_half_bit(CLKS_PER_BIT));

    logic          rx_meta;
    logic [CW-1:0] clk_count;
    logic [2:0]    bit_index;
    logic [7:0]    shift;

    // Both flops reset to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
        end
    end

    // Wraps on its own at the end of each bit so consecutive data bits
    // need no help from the FSM; state changes clear it explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_count <= '0;
        end else if (cnt_clr || clk_count == LAST_CNT) begin
            clk_count <= '0;
        end else begin
            clk_count <= clk_count + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_index <= 3'd0;
        end else if (idx_clr) begin
            bit_index <= 3'd0;
        end else if (idx_inc) begin
            bit_index <= bit_index + 3'd1;
        end
    end

    // Every bit is written before the byte is loaded, so no reset needed.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shift[bit_index] <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= valid_set;
            rx_frame_err <= ferr_set;
            if (byte_load) begin
                rx_byte <= shift;
            end
        end
    end

    assign full_bit_width = (clk_count == LAST_CNT);
    assign half_bit       = (clk_count == HALF_CNT);
    assign last_bit       = (bit_index == 3'd7);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first.
// Detects the start bit on the synchronised line, samples every bit in
// its middle and presents the byte with a one-cycle rx_valid strobe. A low
// stop bit gives a one-cycle rx_frame_err strobe instead, and the receiver
// then waits for the line to return high before looking for a new frame.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   rx_serial     serial line, idle high, asynchronous to clk
//   rx_byte       last correctly framed byte, held until the next one
//   rx_valid      one-cycle pulse, rx_byte updated this cycle
//   rx_frame_err  one-cycle pulse, stop bit was low and byte discarded
//   rx_active     high from the confirmed start bit through the stop sample
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_active
);

    uart_state_e state;
    uart_state_e state_next;

    logic rx_s;
    logic full_bit_width;
    logic half_bit;
    logic last_bit;
    logic cnt_hold;
    logic cnt_clr;
    logic idx_clr;
    logic idx_inc;
    logic shift_en;
    logic byte_load;
    logic valid_set;
    logic ferr_set;

    uart_rx_datapath #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_datapath (
        .clk           (clk),
        .rst           (rst),
        .rx_serial     (rx_serial),
        .cnt_clr       (cnt_clr),
        .idx_clr       (idx_clr),
        .idx_inc       (idx_inc),
        .shift_en      (shift_en),
        .byte_load     (byte_load),
        .valid_set     (valid_set),
        .ferr_set      (ferr_set),
        .rx_s          (rx_s),
        .full_bit_width(full_bit_width),
        .half_bit      (half_bit),
        .last_bit      (last_bit),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_hold   = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        shift_en   = 1'b0;
        byte_load  = 1'b0;
        valid_set  = 1'b0;
        ferr_set   = 1'b0;
        rx_active  = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_hold = 1'b1;
                if (!rx_s) begin
                    state_next = ST_START;
                end
            end

            // Re-check the line mid start bit; a short low pulse is a glitch.
            ST_START: begin
                if (half_bit) begin
                    if (!rx_s) begin
                        state_next = ST_DATA;
                        idx_clr    = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            // The counter was re-based at mid start bit, so its last count
            // falls in the middle of each data bit.
            ST_DATA: begin
                rx_active = 1'b1;
                if (full_bit_width) begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        state_next = ST_STOP;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end

            ST_STOP: begin
                rx_active = 1'b1;
                if (full_bit_width) begin
                    if (rx_s) begin
                        byte_load  = 1'b1;
                        valid_set  = 1'b1;
                        state_next = ST_CLEANUP;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = ST_BREAK;
                    end
                end
            end

            ST_CLEANUP: begin
                state_next = ST_IDLE;
            end

            // Line held low after a bad stop bit: wait it out silently.
            ST_BREAK: begin
                cnt_hold = 1'b1;
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        cnt_clr = cnt_hold || (state_next != state);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT = 8).
// The serial line is driven as a waveform in time units, so the bit period
// can be stretched or shrunk independently of the receiver clock. A small
// reference model records which bytes and frame errors each frame must
// produce; a monitor collects what the receiver actually reports.
module tb_uart_rx;

    localparam int CPB   = 8;
    localparam int CLK_T = 1000;
    localparam int BIT_T = CPB * CLK_T;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_active;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_serial   (rx_serial),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_active   (rx_active)
    );

    always #(CLK_T / 2) clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: what each transmitted frame must produce.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_ferr = 0;
    int         got_ferr = 0;
    logic [7:0] last_good = 8'h00;

    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_ferr++;
        end
    endtask

    // Monitor: collect strobes and watch the cycle-level output rules.
    int         active_cyc = 0;
    logic       prev_strobe = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_byte);
        if (rx_frame_err) got_ferr++;
        if (rx_active) active_cyc++;
        if (rx_valid || rx_frame_err) begin
            check("strobe_exclusive", {31'd0, rx_valid & rx_frame_err}, 32'd0);
            check("strobe_not_consecutive", {31'd0, prev_strobe}, 32'd0);
        end
        if (!rst && !rx_valid && rx_byte !== prev_byte)
            check("byte_hold", {24'd0, rx_byte}, {24'd0, prev_byte});
        prev_strobe = rx_valid | rx_frame_err;
        prev_byte   = rx_byte;
    end

    task automatic verify(input string tag);
        @(negedge clk);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        check({tag, "_ferr"}, got_ferr, exp_ferr);
        check({tag, "_rx_byte"}, {24'd0, rx_byte}, {24'd0, last_good});
        got_q.delete();
        exp_q.delete();
        got_ferr = 0;
        exp_ferr = 0;
    endtask

    // Offset line transitions from the clock edges to avoid sampling races.
    task automatic align();
        @(posedge clk);
        #137;
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; leaves the line
    // at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int bt);
        rx_serial = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            #(bt);
        end
        rx_serial = stop_hi;
        #(bt);
    endtask

    initial begin
        int bt;
        int gap;
        logic [7:0] b;
        bit ok;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_byte", {24'd0, rx_byte}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check("reset_rx_active", {31'd0, rx_active}, 32'd0);
        align();
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Single frame at exact baud
        active_cyc = 0;
        align();
        send_frame(8'hA5, 1'b1, BIT_T);
        model_frame(8'hA5, 1'b1);
        #(2 * BIT_T);
        verify("a5");
        check("a5_active_cycles", active_cyc, 9 * CPB);

        // Back-to-back frames, no idle between
        align();
        send_frame(8'h00, 1'b1, BIT_T);
        send_frame(8'hFF, 1'b1, BIT_T);
        send_frame(8'h3C, 1'b1, BIT_T);
        model_frame(8'h00, 1'b1);
        model_frame(8'hFF, 1'b1);
        model_frame(8'h3C, 1'b1);
        #(2 * BIT_T);
        verify("b2b");

        // Two-cycle glitch on the idle line
        active_cyc = 0;
        align();
        rx_serial = 1'b0;
        #(2 * CLK_T);
        rx_serial = 1'b1;
        #(3 * BIT_T);
        verify("glitch");
        check("glitch_active_cycles", active_cyc, 0);

        // Bad stop bit, line held low, then a clean frame
        align();
        send_frame(8'h5A, 1'b0, BIT_T);
        model_frame(8'h5A, 1'b0);
        #(40 * CLK_T);
        rx_serial = 1'b1;
        #(2 * BIT_T);
        verify("frame_err");
        align();
        send_frame(8'h12, 1'b1, BIT_T);
        model_frame(8'h12, 1'b1);
        #(2 * BIT_T);
        verify("after_break");

        // Reset in the middle of a frame
        align();
        fork
            send_frame(8'hC3, 1'b1, BIT_T);
            begin
                repeat (40) @(posedge clk);
                @(negedge clk);
                check("mid_frame_active", {31'd0, rx_active}, 32'd1);
                #137;
                rst = 1'b1;
                last_good = 8'h00;
                repeat (2) @(negedge clk);
                check("mid_reset_rx_byte", {24'd0, rx_byte}, 32'd0);
                check("mid_reset_rx_valid", {31'd0, rx_valid}, 32'd0);
                check("mid_reset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
                check("mid_reset_rx_active", {31'd0, rx_active}, 32'd0);
            end
        join
        align();
        rst = 1'b0;
        #(2 * BIT_T);
        verify("aborted");
        align();
        send_frame(8'h81, 1'b1, BIT_T);
        model_frame(8'h81, 1'b1);
        #(2 * BIT_T);
        verify("after_reset");

        // Random bytes with the transmitter bit period off by -3%, 0, +3%
        for (int n = 0; n < 256; n++) begin
            case ($urandom_range(0, 2))
                0:       bt = (BIT_T * 97) / 100;
                1:       bt = BIT_T;
                default: bt = (BIT_T * 103) / 100;
            endcase
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 7) != 0);
            gap = $urandom_range(1, 3);
            align();
            send_frame(b, ok, bt);
            model_frame(b, ok);
            rx_serial = 1'b1;
            #(gap * BIT_T);
            verify("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
